// File: rtl/gearbox_2_to_1.sv
// -----------------------------------------------------------------------------
// gearbox_2_to_1
//
// Purpose
//   Splits a stream of 2*width-bit words into a stream of width-bit beats.
//   A wide word {first, second} comes out as two narrow beats, in that order.
//   Two word slots let the downstream side run at one beat per cycle while
//   the upstream side delivers one word every two cycles.
//
//   Slot A holds the word being split, together with a phase bit:
//     phase 0 - first beat pending
//     phase 1 - second beat pending
//   Slot B holds the next word, waiting for A to retire.
//
// Parameters
//   width      narrow (downstream) data width; upstream width is 2*width
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   up_vld     upstream word valid
//   up_rdy     upstream ready; a word transfers when up_vld && up_rdy
//   up_data    upstream wide word
//   down_vld   downstream beat valid
//   down_rdy   downstream ready; a beat transfers when down_vld && down_rdy
//   down_data  downstream narrow beat (zero whenever down_vld is low)
//   down_last  high on the second beat of a wide word
//
// Configuration
//   GEARBOX_2_TO_1_LSB_FIRST_EN  if defined, the low half is sent first.
//                                Otherwise the high half is sent first.
// -----------------------------------------------------------------------------
module gearbox_2_to_1 #(
    parameter int width = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up_vld,
    output logic               up_rdy,
    input  logic [2*width-1:0] up_data,
    output logic               down_vld,
    input  logic               down_rdy,
    output logic [width-1:0]   down_data,
    output logic               down_last
);

    // Slot A: word being split, and its phase.
    logic               a_vld_q, a_vld_d;
    logic [2*width-1:0] a_data_q, a_data_d;
    logic               phase_q, phase_d;

    // Slot B: next word.
    logic               b_vld_q, b_vld_d;
    logic [2*width-1:0] b_data_q, b_data_d;

    logic               up_fire;
    logic               down_fire;
    logic               a_retire;
    logic [width-1:0]   first_half;
    logic [width-1:0]   second_half;

    // up_rdy depends only on state and rst, so no combinational path exists
    // from down_rdy or up_vld to up_rdy.
    assign up_rdy    = !rst && !b_vld_q;
    assign up_fire   = up_vld && up_rdy;

    // The outputs are gated by rst. This keeps them quiet during the reset
    // cycle itself, before the state registers have been cleared.
    assign down_vld  = a_vld_q && !rst;
    assign down_fire = down_vld && down_rdy;
    assign a_retire  = down_fire && phase_q;

`ifdef GEARBOX_2_TO_1_LSB_FIRST_EN
    assign first_half  = a_data_q[width-1:0];
    assign second_half = a_data_q[2*width-1:width];
`else
    assign first_half  = a_data_q[2*width-1:width];
    assign second_half = a_data_q[width-1:0];
`endif

    // Beats come from registered slot A only, so no path exists from
    // up_data to down_data.
    assign down_data = down_vld ? (phase_q ? second_half : first_half) : '0;
    assign down_last = down_vld && phase_q;

    always_comb begin
        a_vld_d  = a_vld_q;
        a_data_d = a_data_q;
        phase_d  = phase_q;
        b_vld_d  = b_vld_q;
        b_data_d = b_data_q;

        if (a_retire) begin
            // The second beat left this cycle. Refill A from B first, then
            // from the upstream port. When B is full, up_rdy is low, so at
            // most one of these sources can be live.
            if (b_vld_q) begin
                a_vld_d  = 1'b1;
                a_data_d = b_data_q;
                b_vld_d  = 1'b0;
            end else if (up_fire) begin
                a_vld_d  = 1'b1;
                a_data_d = up_data;
            end else begin
                a_vld_d  = 1'b0;
            end
            phase_d = 1'b0;
        end else begin
            if (down_fire) begin
                // The first beat left; A now holds the second beat.
                phase_d = 1'b1;
            end
            if (up_fire) begin
                if (!a_vld_q) begin
                    // B is never occupied while A is empty.
                    a_vld_d  = 1'b1;
                    a_data_d = up_data;
                    phase_d  = 1'b0;
                end else begin
                    b_vld_d  = 1'b1;
                    b_data_d = up_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_q  <= 1'b0;
            a_data_q <= '0;
            phase_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            b_data_q <= '0;
        end else begin
            a_vld_q  <= a_vld_d;
            a_data_q <= a_data_d;
            phase_q  <= phase_d;
            b_vld_q  <= b_vld_d;
            b_data_q <= b_data_d;
        end
    end

endmodule
